// File: rtl/iir_coeff_sequencer_if.sv
// Coefficient write channel into the IIR coefficient sequencer.
// The master drives the request; the slave (the sequencer) returns wr_ready.
interface iir_coeff_sequencer_if #(
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned COEFF_WIDTH = 8
) ();
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COEFF_WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/iir_coeff_sequencer.sv
// Shadow/active coefficient banks for the IIR filter. A commit is applied at a sample
// boundary, after which the filter is held in reset for FLUSH_CYCLES cycles.
module iir_coeff_sequencer #(
    parameter int unsigned M            = 2,
    parameter int unsigned COEFF_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    iir_coeff_sequencer_if.slave         wr,
    input  logic                         commit,
    input  logic                         sample_en,
    output logic [COEFF_WIDTH*(M+1)-1:0] packed_b_coeffs,
    output logic [COEFF_WIDTH*M-1:0]     packed_a_coeffs,
    output logic                         iir_rst_n,
    output logic                         busy,
    output logic                         commit_done,
    output logic                         addr_err
);
    localparam int unsigned N          = M + 1;
    localparam int unsigned NUM_COEFFS = N + M;
    localparam int unsigned B_W        = COEFF_WIDTH * N;
    localparam int unsigned A_W        = COEFF_WIDTH * M;
    localparam int unsigned CNT_W      = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             reset_flush_q, reset_flush_d;
    logic [B_W-1:0]   shadow_b_q, shadow_b_d, active_b_q, active_b_d;
    logic [A_W-1:0]   shadow_a_q, shadow_a_d, active_a_q, active_a_d;
    logic             wr_ready_q, wr_ready_d;
    logic             iir_rst_n_q, iir_rst_n_d;
    logic             busy_q, busy_d;
    logic             commit_done_q, commit_done_d;
    logic             addr_err_q, addr_err_d;
    logic             wr_fire;
    int unsigned      addr_i;

    // State and output registers; reset lands in a flush that reports no commit_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FLUSH;
            cnt_q         <= CNT_W'(FLUSH_CYCLES);
            reset_flush_q <= 1'b1;
            shadow_b_q    <= '0;
            shadow_a_q    <= '0;
            active_b_q    <= '0;
            active_a_q    <= '0;
            wr_ready_q    <= 1'b0;
            iir_rst_n_q   <= 1'b0;
            busy_q        <= 1'b1;
            commit_done_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reset_flush_q <= reset_flush_d;
            shadow_b_q    <= shadow_b_d;
            shadow_a_q    <= shadow_a_d;
            active_b_q    <= active_b_d;
            active_a_q    <= active_a_d;
            wr_ready_q    <= wr_ready_d;
            iir_rst_n_q   <= iir_rst_n_d;
            busy_q        <= busy_d;
            commit_done_q <= commit_done_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reset_flush_d = reset_flush_q;
        shadow_b_d    = shadow_b_q;
        shadow_a_d    = shadow_a_q;
        active_b_d    = active_b_q;
        active_a_d    = active_a_q;
        wr_ready_d    = wr_ready_q;
        iir_rst_n_d   = iir_rst_n_q;
        busy_d        = busy_q;
        commit_done_d = 1'b0;
        addr_err_d    = 1'b0;
        addr_i        = 32'(wr.wr_addr);
        wr_fire       = wr.wr_valid & wr_ready_q;

        // wr_ready is only high in IDLE, so writes never land outside it
        if (wr_fire) begin
            if (addr_i >= NUM_COEFFS) begin
                addr_err_d = 1'b1;
            end
            for (int unsigned t = 0; t < N; t++) begin
                if (addr_i == t) shadow_b_d[COEFF_WIDTH*t +: COEFF_WIDTH] = wr.wr_data;
            end
            for (int unsigned t = 0; t < M; t++) begin
                if (addr_i == N + t) shadow_a_d[COEFF_WIDTH*t +: COEFF_WIDTH] = wr.wr_data;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d    = ST_ARMED;
                    wr_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (sample_en) begin
                    active_b_d    = shadow_b_q;
                    active_a_d    = shadow_a_q;
                    state_d       = ST_FLUSH;
                    cnt_d         = CNT_W'(FLUSH_CYCLES);
                    reset_flush_d = 1'b0;
                    iir_rst_n_d   = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d       = ST_IDLE;
                    wr_ready_d    = 1'b1;
                    busy_d        = 1'b0;
                    iir_rst_n_d   = 1'b1;
                    commit_done_d = ~reset_flush_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                wr_ready_d  = 1'b1;
                busy_d      = 1'b0;
                iir_rst_n_d = 1'b1;
            end
        endcase
    end

    assign wr.wr_ready       = wr_ready_q;
    assign packed_b_coeffs   = active_b_q;
    assign packed_a_coeffs   = active_a_q;
    assign iir_rst_n         = iir_rst_n_q;
    assign busy              = busy_q;
    assign commit_done       = commit_done_q;
    assign addr_err          = addr_err_q;
endmodule

// File: tb/tb_iir_coeff_sequencer.sv
// Directed and random stimulus for iir_coeff_sequencer, checked every cycle against a
// transaction-level model of the banks and the flush timer.
module tb_iir_coeff_sequencer;
    localparam int unsigned M  = 2;
    localparam int unsigned N  = 3;
    localparam int unsigned NC = 5;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned FL = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            commit;
    logic            sample_en;
    logic [CW*N-1:0] packed_b_coeffs;
    logic [CW*M-1:0] packed_a_coeffs;
    logic            iir_rst_n;
    logic            busy;
    logic            commit_done;
    logic            addr_err;

    iir_coeff_sequencer_if #(.ADDR_WIDTH(AW), .COEFF_WIDTH(CW)) wif ();

    iir_coeff_sequencer #(.M(M), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FL)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr              (wif.slave),
        .commit          (commit),
        .sample_en       (sample_en),
        .packed_b_coeffs (packed_b_coeffs),
        .packed_a_coeffs (packed_a_coeffs),
        .iir_rst_n       (iir_rst_n),
        .busy            (busy),
        .commit_done     (commit_done),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    // Reference model: coefficient arrays, an armed flag and the number of reset cycles left
    logic [CW-1:0] sh  [NC];
    logic [CW-1:0] act [NC];
    bit            m_armed;
    int            m_low_left;
    bit            m_quiet;
    bit            m_done;
    bit            m_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW*N-1:0] exp_b();
        logic [CW*N-1:0] r;
        for (int t = 0; t < N; t++) r[CW*t +: CW] = act[t];
        return r;
    endfunction

    function automatic logic [CW*M-1:0] exp_a();
        logic [CW*M-1:0] r;
        for (int t = 0; t < M; t++) r[CW*t +: CW] = act[N+t];
        return r;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [AW-1:0] a,
                              input logic [CW-1:0] d, input logic c, input logic s);
        bit idle;
        if (r) begin
            foreach (sh[i]) begin sh[i] = '0; act[i] = '0; end
            m_armed = 0; m_low_left = FL; m_quiet = 1; m_done = 0; m_err = 0;
            return;
        end
        idle   = !m_armed && m_low_left == 0;
        m_done = 0;
        m_err  = 0;
        if (idle && v) begin
            if (int'(a) < NC) sh[a] = d;
            else m_err = 1;
        end
        if (m_low_left > 0) begin
            m_low_left--;
            if (m_low_left == 0 && !m_quiet) m_done = 1;
        end else if (m_armed && s) begin
            foreach (sh[i]) act[i] = sh[i];
            m_armed = 0; m_low_left = FL; m_quiet = 0;
        end else if (idle && c) begin
            m_armed = 1;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [AW-1:0] a,
                        input logic [CW-1:0] d, input logic c, input logic s);
        rst = r; wif.wr_valid = v; wif.wr_addr = a; wif.wr_data = d;
        commit = c; sample_en = s;
        @(posedge clk);
        model_edge(r, v, a, d, c, s);
        #1;
        chk("packed_b",    64'(packed_b_coeffs), 64'(exp_b()));
        chk("packed_a",    64'(packed_a_coeffs), 64'(exp_a()));
        chk("wr_ready",    64'(wif.wr_ready),    64'(!m_armed && m_low_left == 0));
        chk("busy",        64'(busy),            64'(m_armed || m_low_left > 0));
        chk("iir_rst_n",   64'(iir_rst_n),       64'(m_low_left == 0));
        chk("commit_done", 64'(commit_done),     64'(m_done));
        chk("addr_err",    64'(addr_err),        64'(m_err));
        if (commit_done) done_seen++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wif.wr_valid = 1'b0; wif.wr_addr = '0; wif.wr_data = '0;
        commit = 1'b0; sample_en = 1'b0;

        // Reset release: 4-cycle silent flush
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle_cycles(6);

        // Full coefficient set, commit, sample boundary three cycles later
        step(1'b0, 1'b1, 3'd0, 8'h10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd1, 8'h20, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h10, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd3, 8'hF0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd4, 8'h08, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle_cycles(2);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle_cycles(6);
        chk("b_after_swap", 64'(packed_b_coeffs), 64'h102010);
        chk("a_after_swap", 64'(packed_a_coeffs), 64'h08F0);

        // Out-of-range write
        step(1'b0, 1'b1, 3'd7, 8'hAA, 1'b0, 1'b0);
        idle_cycles(2);

        // Write in the commit cycle, commit held through ARMED
        done_seen = 0;
        step(1'b0, 1'b1, 3'd0, 8'h55, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        idle_cycles(8);
        chk("single_done", 64'(done_seen), 64'd1);
        chk("b0_55", 64'(packed_b_coeffs), 64'h102055);

        // Write attempt while ARMED is refused
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 8'h7F, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 8'h7F, 1'b0, 1'b1);
        idle_cycles(6);

        // Reset in the middle of a flush
        step(1'b0, 1'b1, 3'd2, 8'h33, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle_cycles(2);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle_cycles(6);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)), CW'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/iir_coeff_sequencer.md
# iir_coeff_sequencer

Configuration controller for the IIR filter datapath. It accepts coefficient writes through a valid/ready handshake into a shadow bank, then applies the whole bank atomically at a sample boundary. After applying, it holds the filter's delay lines in reset for a fixed flush period so that no output is ever computed from a mix of old and new coefficients. It sits between the oscilloscope's control/register interface and the filter, and drives the filter's packed coefficient buses and its active-low reset.

## Interface
- M, 2, filter order; N = M+1 feed-forward taps (local).
- COEFF_WIDTH, 8, signed coefficient width.
- ADDR_WIDTH, 3, write address width; must satisfy 2^ADDR_WIDTH >= N+M.
- FLUSH_CYCLES, 4, cycles the filter is held in reset after a swap; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  coefficient write request.
- wr_ready  out  1  write accepted when high with wr_valid.
- wr_addr  in  ADDR_WIDTH  0..N-1 selects b[addr]; N..N+M-1 selects a[addr-N].
- wr_data  in  COEFF_WIDTH  coefficient value.
- commit  in  1  request to apply the shadow bank (level, sampled only in IDLE).
- sample_en  in  1  one-cycle strobe marking a filter sample boundary.
- packed_b_coeffs  out  COEFF_WIDTH*N  active b coefficients; b[t] at bits [COEFF_WIDTH*t +: COEFF_WIDTH].
- packed_a_coeffs  out  COEFF_WIDTH*M  active a coefficients; same packing.
- iir_rst_n  out  1  active-low reset to the filter.
- busy  out  1  high in ARMED or FLUSH.
- commit_done  out  1  one-cycle pulse when a commit completes.
- addr_err  out  1  one-cycle pulse on an accepted write to an out-of-range address.

## Operation
- States: IDLE, ARMED, FLUSH. All outputs are registered.
- Reset (rst high at an edge):
  - Shadow and active banks cleared to 0.
  - State becomes FLUSH with the flush counter loaded to FLUSH_CYCLES.
  - iir_rst_n=0, busy=1, wr_ready=0, commit_done=0, addr_err=0.
  - The flush runs after rst deasserts, so the filter is held in reset for FLUSH_CYCLES cycles. The commit_done pulse is suppressed for this reset flush.
- IDLE:
  - wr_ready=1, iir_rst_n=1, busy=0.
  - A write (wr_valid & wr_ready) with addr < N+M stores wr_data into the shadow entry.
  - A write to an out-of-range address is accepted and discarded, and addr_err pulses on the next cycle.
  - commit=1 moves the state to ARMED. A write accepted in the same cycle as commit is included in that commit.
- ARMED:
  - wr_ready=0, busy=1. Further commits are ignored.
  - When sample_en=1, the active bank is loaded with the shadow bank at that edge, the state becomes FLUSH, and the counter is loaded to FLUSH_CYCLES.
- FLUSH:
  - iir_rst_n=0, wr_ready=0. The counter decrements once per cycle.
  - sample_en and commit are ignored.
  - When the counter reaches the terminal count, the state returns to IDLE and commit_done pulses, except after a reset flush.
- The shadow bank is never altered by a commit. Uncommitted writes persist until overwritten.
- rst asserted in any state, including mid-flush or while ARMED, aborts the operation. The pending commit is dropped and every register returns to its reset value.

## Timing
- A write accepted at edge W is visible in the shadow bank from W+1. The active bank is never affected until a swap.
- commit sampled at edge C: busy=1 and wr_ready=0 from C+1.
  - sample_en in the same cycle as commit is not used; the earliest swap edge is C+1.
- Swap at edge S: new packed_*_coeffs and iir_rst_n=0 from S+1.
  - iir_rst_n stays 0 for exactly FLUSH_CYCLES cycles, S+1 .. S+FLUSH_CYCLES.
  - At S+FLUSH_CYCLES+1: iir_rst_n=1, busy=0, wr_ready=1, and commit_done=1 for that one cycle.
- Reset flush: rst high at edge R (last) gives iir_rst_n=0 through R+FLUSH_CYCLES and 1 from R+FLUSH_CYCLES+1, with no commit_done.
- The minimum commit-to-done latency is FLUSH_CYCLES+2 cycles, with sample_en high on the first ARMED cycle.

## Test plan
- Reset release with FLUSH_CYCLES=4: iir_rst_n low for 4 cycles after rst drops, then high; coefficients all 0; commit_done never pulses.
- Write b0=0x10, b1=0x20, b2=0x10, a0=0xF0 (addr 3), a1=0x08, then commit, then sample_en 3 cycles later:
  - packed_b_coeffs=0x102010 and packed_a_coeffs=0x08F0 appear only after the sample_en edge.
  - iir_rst_n low for 4 cycles, then commit_done pulses.
- Write to addr 7 with M=2: addr_err pulses once, and both banks are unchanged.
- Write b0=0x55 in the same cycle as commit: the swap includes 0x55. Hold commit high through ARMED: exactly one commit_done results.
- While ARMED, drive wr_valid with addr 0 and data 0x7F: wr_ready stays 0, and neither bank changes until after commit_done.
- Assert rst during FLUSH (counter at 2): all outputs take their reset values, the active bank is cleared, and a new 4-cycle reset flush runs.
